// File: rtl/fir_coeff_seq_pkg.sv
// Shared types and defaults for fir_coeff_sequencer.
// FIR_COEFF_SEQ_AUTOLOAD_EN (top) enables the bank-0 load after reset.
package fir_coeff_seq_pkg;

    localparam int DEF_NUMBER_TAPS       = 16;
    localparam int DEF_COEFFICIENT_WIDTH = 16;
    localparam int DEF_C_AXI_DATA_WIDTH  = 32;
    localparam int DEF_NUM_BANKS         = 4;
    localparam int DEF_CLEAR_CYCLES      = 2;

    localparam int DEF_BANK_W = $clog2(DEF_NUM_BANKS);
    localparam int DEF_IDX_W  = $clog2(DEF_NUMBER_TAPS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_QUIET,
        CLEAR,
        LOAD,
        DONE
    } seq_state_t;

    function automatic logic [DEF_C_AXI_DATA_WIDTH-1:0] sext(
        input logic [DEF_COEFFICIENT_WIDTH-1:0] c
    );
        return DEF_C_AXI_DATA_WIDTH'($signed(c));
    endfunction

endpackage

// File: rtl/fir_coeff_sequencer_bank_ram.sv
// Coefficient table: NUM_BANKS x NUMBER_TAPS flops, one write port,
// one combinational read port. Contents survive reset.
module fir_coeff_bank_ram
    import fir_coeff_seq_pkg::*;
#(
    parameter int NUMBER_TAPS       = DEF_NUMBER_TAPS,
    parameter int COEFFICIENT_WIDTH = DEF_COEFFICIENT_WIDTH,
    parameter int NUM_BANKS         = DEF_NUM_BANKS,
    localparam int BW = $clog2(NUM_BANKS),
    localparam int IW = $clog2(NUMBER_TAPS)
) (
    input  logic                         clock,
    input  logic                         we,
    input  logic [BW-1:0]                wr_bank,
    input  logic [IW-1:0]                wr_index,
    input  logic [COEFFICIENT_WIDTH-1:0] wr_data,
    input  logic [BW-1:0]                rd_bank,
    input  logic [IW-1:0]                rd_index,
    output logic [COEFFICIENT_WIDTH-1:0] rd_data
);

    logic [COEFFICIENT_WIDTH-1:0] mem [NUM_BANKS][NUMBER_TAPS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_bank][wr_index] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_index];

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Streams one of NUM_BANKS coefficient sets into a fir_filter.
// Define FIR_COEFF_SEQ_AUTOLOAD_EN to load bank 0 after reset release.
module fir_coeff_sequencer
    import fir_coeff_seq_pkg::*;
#(
    parameter int NUMBER_TAPS       = DEF_NUMBER_TAPS,
    parameter int COEFFICIENT_WIDTH = DEF_COEFFICIENT_WIDTH,
    parameter int C_AXI_DATA_WIDTH  = DEF_C_AXI_DATA_WIDTH,
    parameter int NUM_BANKS         = DEF_NUM_BANKS,
    parameter int CLEAR_CYCLES      = DEF_CLEAR_CYCLES,
    localparam int BW   = $clog2(NUM_BANKS),
    localparam int IW   = $clog2(NUMBER_TAPS),
    localparam int CNTW = $clog2(CLEAR_CYCLES + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         tbl_we,
    input  logic [BW-1:0]                tbl_bank,
    input  logic [IW-1:0]                tbl_index,
    input  logic [COEFFICIENT_WIDTH-1:0] tbl_data,
    output logic                         tbl_err,
    input  logic                         switch_req,
    input  logic [BW-1:0]                switch_bank,
    output logic                         switch_ack,
    output logic                         busy,
    output logic [BW-1:0]                active_bank,
    output logic                         coeffs_loaded,
    input  logic                         frame_active,
    input  logic                         samples_remaining,
    output logic                         hold_input,
    output logic                         coeffs_aresetn,
    output logic                         coeffs_wvalid,
    input  logic                         coeffs_wready,
    output logic [C_AXI_DATA_WIDTH-1:0]  coeffs_wdata
);

    seq_state_t state, state_nxt;

    logic [BW-1:0]                target;
    logic [BW-1:0]                active_q;
    logic [IW-1:0]                idx;
    logic [CNTW-1:0]              clr_cnt;
    logic                         loaded_q;
    logic                         beat;
    logic                         last_beat;
    logic                         clr_done;
    logic                         quiet;
    logic                         drop;
    logic                         auto_go;
    logic [COEFFICIENT_WIDTH-1:0] rd_data;

`ifdef FIR_COEFF_SEQ_AUTOLOAD_EN
    logic auto_pend;

    always_ff @(posedge clock) begin
        if (reset) begin
            auto_pend <= 1'b1;
        end else if (state == IDLE) begin
            auto_pend <= 1'b0;
        end
    end

    assign auto_go = auto_pend;
`else
    assign auto_go = 1'b0;
`endif

    assign beat      = (state == LOAD) && coeffs_wready;
    assign last_beat = beat && (idx == IW'(NUMBER_TAPS - 1));
    assign clr_done  = (clr_cnt == CNTW'(CLEAR_CYCLES - 1));
    assign quiet     = !frame_active && !samples_remaining;

    // Writes into the bank being streamed would tear the load.
    assign drop    = tbl_we && (state != IDLE) && (tbl_bank == target);
    assign tbl_err = drop;

    fir_coeff_bank_ram #(
        .NUMBER_TAPS      (NUMBER_TAPS),
        .COEFFICIENT_WIDTH(COEFFICIENT_WIDTH),
        .NUM_BANKS        (NUM_BANKS)
    ) u_ram (
        .clock   (clock),
        .we      (tbl_we && !drop),
        .wr_bank (tbl_bank),
        .wr_index(tbl_index),
        .wr_data (tbl_data),
        .rd_bank (target),
        .rd_index(idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b1;
        hold_input     = 1'b1;
        coeffs_aresetn = 1'b1;
        coeffs_wvalid  = 1'b0;
        coeffs_wdata   = '0;
        switch_ack     = 1'b0;
        unique case (state)
            IDLE: begin
                busy       = 1'b0;
                hold_input = 1'b0;
                if (auto_go) begin
                    state_nxt = CLEAR;
                end else if (switch_req) begin
                    state_nxt = WAIT_QUIET;
                end
            end
            WAIT_QUIET: begin
                if (quiet) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                coeffs_aresetn = 1'b0;
                if (clr_done) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                coeffs_wvalid = 1'b1;
                coeffs_wdata  = C_AXI_DATA_WIDTH'($signed(rd_data));
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                switch_ack = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            target   <= '0;
            idx      <= '0;
            clr_cnt  <= '0;
            active_q <= '0;
            loaded_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    idx     <= '0;
                    clr_cnt <= '0;
                    if (auto_go) begin
                        target <= '0;
                    end else if (switch_req) begin
                        target <= switch_bank;
                    end
                end
                WAIT_QUIET: clr_cnt <= '0;
                CLEAR:      clr_cnt <= clr_cnt + CNTW'(1);
                LOAD: begin
                    if (beat) begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    active_q <= target;
                    loaded_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign active_bank   = active_q;
    assign coeffs_loaded = loaded_q;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Randomized self-checking bench for fir_coeff_sequencer.
// Reference: coefficient table array plus load-timeline rules.
module tb_fir_coeff_sequencer;

    localparam int NT = 16;
    localparam int NB = 4;
    localparam int CC = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        tbl_we;
    logic [1:0]  tbl_bank;
    logic [3:0]  tbl_index;
    logic [15:0] tbl_data;
    logic        tbl_err;
    logic        switch_req;
    logic [1:0]  switch_bank;
    logic        switch_ack;
    logic        busy;
    logic [1:0]  active_bank;
    logic        coeffs_loaded;
    logic        frame_active;
    logic        samples_remaining;
    logic        hold_input;
    logic        coeffs_aresetn;
    logic        coeffs_wvalid;
    logic        coeffs_wready;
    logic [31:0] coeffs_wdata;

    fir_coeff_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .tbl_we           (tbl_we),
        .tbl_bank         (tbl_bank),
        .tbl_index        (tbl_index),
        .tbl_data         (tbl_data),
        .tbl_err          (tbl_err),
        .switch_req       (switch_req),
        .switch_bank      (switch_bank),
        .switch_ack       (switch_ack),
        .busy             (busy),
        .active_bank      (active_bank),
        .coeffs_loaded    (coeffs_loaded),
        .frame_active     (frame_active),
        .samples_remaining(samples_remaining),
        .hold_input       (hold_input),
        .coeffs_aresetn   (coeffs_aresetn),
        .coeffs_wvalid    (coeffs_wvalid),
        .coeffs_wready    (coeffs_wready),
        .coeffs_wdata     (coeffs_wdata)
    );

    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;

    logic [15:0] tbl [NB][NT];
    bit          known = 1'b0;
    int          m_active = 0;
    bit          m_loaded = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] c);
        int v;
        v = c;
        if (v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        tbl_we            = 1'b0;
        switch_req        = 1'b0;
        frame_active      = 1'b0;
        samples_remaining = 1'b0;
        coeffs_wready     = 1'b0;
    endtask

    task automatic after_reset();
`ifdef FIR_COEFF_SEQ_AUTOLOAD_EN
        int k = 0;
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            step();
            idle_in();
            coeffs_wready = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (coeffs_wvalid && coeffs_wready) begin
                if (known && k < NT) check("auto_wdata", coeffs_wdata, sx(tbl[0][k]));
                k++;
            end
            if (switch_ack) done = 1'b1;
        end
        check("auto_ack", 32'(done), 1);
        check("auto_beats", 32'(k), NT);
        step();
        idle_in();
        @(negedge clock);
        check("auto_loaded", 32'(coeffs_loaded), 1);
        check("auto_bank", 32'(active_bank), 0);
        check("auto_busy", 32'(busy), 0);
        m_loaded = 1'b1;
        m_active = 0;
`else
        for (int n = 0; n < 4; n++) begin
            step();
            idle_in();
            @(negedge clock);
            check("idle_busy", 32'(busy), 0);
            check("idle_aresetn", 32'(coeffs_aresetn), 1);
            check("idle_wvalid", 32'(coeffs_wvalid), 0);
        end
`endif
    endtask

    task automatic reset_state_checks(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_aresetn"}, 32'(coeffs_aresetn), 1);
        check({tag, "_wvalid"}, 32'(coeffs_wvalid), 0);
        check({tag, "_wdata"}, coeffs_wdata, 0);
        check({tag, "_ack"}, 32'(switch_ack), 0);
        check({tag, "_hold"}, 32'(hold_input), 0);
        check({tag, "_active"}, 32'(active_bank), 0);
        check({tag, "_loaded"}, 32'(coeffs_loaded), 0);
        check({tag, "_err"}, 32'(tbl_err), 0);
    endtask

    task automatic do_reset();
        step();
        idle_in();
        reset = 1'b1;
        @(negedge clock);
        step();
        reset = 1'b0;
        @(negedge clock);
        m_active = 0;
        m_loaded = 1'b0;
        reset_state_checks("rst");
        after_reset();
    endtask

    task automatic tbl_write(input int b, input int i, input logic [15:0] d);
        step();
        idle_in();
        tbl_we    = 1'b1;
        tbl_bank  = 2'(b);
        tbl_index = 4'(i);
        tbl_data  = d;
        @(negedge clock);
        check("wr_err", 32'(tbl_err), 0);
        tbl[b][i] = d;
    endtask

    task automatic run_load(input int b, input int w, input int mode,
                            input int rst_beat, input bit same_wr,
                            input bit busy_wr);
        logic [15:0] exp [NT];
        int acc = 0;
        int stalls = 0;
        int ackn = -1;
        bit prev_stall = 1'b0;
        bit was_valid = 1'b0;
        bit e1 = 1'b0;
        bit e2 = 1'b0;
        bit err_exp;
        logic [31:0] prev_d = '0;
        logic [15:0] d;
        int ob;
        int wi;

        step();
        idle_in();
        switch_req  = 1'b1;
        switch_bank = 2'(b);
        if (same_wr) begin
            d         = 16'($urandom);
            tbl_we    = 1'b1;
            tbl_bank  = 2'(b);
            tbl_index = 4'd0;
            tbl_data  = d;
            tbl[b][0] = d;
        end
        for (int i = 0; i < NT; i++) exp[i] = tbl[b][i];
        @(negedge clock);
        check("req_busy", 32'(busy), 0);
        check("req_err", 32'(tbl_err), 0);

        for (int n = 1; n < 400 && ackn < 0; n++) begin
            step();
            idle_in();
            err_exp           = 1'b0;
            frame_active      = (n <= (w + 1) / 2);
            samples_remaining = (n > w / 2) && (n <= w);
            case (mode)
                0:       coeffs_wready = 1'b1;
                1:       coeffs_wready = (n % 2 == 0);
                default: coeffs_wready = 1'($urandom_range(0, 1));
            endcase
            if (rst_beat >= 0 && was_valid && acc == rst_beat) begin
                reset = 1'b1;
                @(negedge clock);
                step();
                idle_in();
                reset = 1'b0;
                @(negedge clock);
                m_active = 0;
                m_loaded = 1'b0;
                reset_state_checks("midrst");
                after_reset();
                return;
            end
            if (busy_wr && was_valid && acc >= 3 && !e1) begin
                e1          = 1'b1;
                err_exp     = 1'b1;
                wi          = $urandom_range(0, NT - 1);
                tbl_we      = 1'b1;
                tbl_bank    = 2'(b);
                tbl_index   = 4'(wi);
                tbl_data    = ~tbl[b][wi];
                switch_req  = 1'b1;
                switch_bank = 2'((b + 1) % NB);
            end else if (busy_wr && was_valid && acc >= 5 && !e2) begin
                e2        = 1'b1;
                ob        = (b + 1) % NB;
                wi        = $urandom_range(0, NT - 1);
                d         = 16'($urandom);
                tbl_we    = 1'b1;
                tbl_bank  = 2'(ob);
                tbl_index = 4'(wi);
                tbl_data  = d;
                tbl[ob][wi] = d;
            end
            @(negedge clock);
            check("busy", 32'(busy), 1);
            check("hold", 32'(hold_input), 1);
            check("tbl_err", 32'(tbl_err), 32'(err_exp));
            check("aresetn", 32'(coeffs_aresetn),
                  (n >= w + 2 && n < w + 2 + CC) ? 0 : 1);
            check("wvalid", 32'(coeffs_wvalid),
                  32'(n >= w + 2 + CC && acc < NT));
            check("ack", 32'(switch_ack), 32'(acc == NT));
            if (prev_stall) check("stall_hold", coeffs_wdata, prev_d);
            if (switch_ack) begin
                ackn = n;
                check("ack_cycle", 32'(n), 32'(w + 2 + CC + NT + stalls));
            end
            if (coeffs_wvalid && coeffs_wready && acc < NT) begin
                check("beat", coeffs_wdata, sx(exp[acc]));
                acc++;
            end
            prev_stall = coeffs_wvalid && !coeffs_wready;
            if (prev_stall) stalls++;
            prev_d    = coeffs_wdata;
            was_valid = coeffs_wvalid;
        end
        check("ack_seen", 32'(ackn >= 0), 1);
        check("beats", 32'(acc), NT);
        m_active = b;
        m_loaded = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            idle_in();
            @(negedge clock);
            check("post_busy", 32'(busy), 0);
            check("post_hold", 32'(hold_input), 0);
            check("post_ack", 32'(switch_ack), 0);
            check("post_active", 32'(active_bank), 32'(m_active));
            check("post_loaded", 32'(coeffs_loaded), 32'(m_loaded));
        end
    endtask

    initial begin
        reset       = 1'b1;
        tbl_bank    = '0;
        tbl_index   = '0;
        tbl_data    = '0;
        switch_bank = '0;
        idle_in();
        repeat (2) @(posedge clock);
        do_reset();

        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < NT; i++) begin
                tbl_write(b, i, (b == 1) ? 16'(16'h8000 + i) : 16'($urandom));
            end
        end
        known = 1'b1;

        run_load(1, 0, 0, -1, 1'b0, 1'b0);
        run_load(2, 50, 0, -1, 1'b0, 1'b0);
        run_load(3, 0, 1, -1, 1'b0, 1'b0);
        run_load(2, 3, 0, -1, 1'b0, 1'b1);
        run_load(3, 0, 0, -1, 1'b0, 1'b0);
        run_load(2, 0, 2, -1, 1'b0, 1'b0);
        run_load(0, 0, 0, 7, 1'b0, 1'b0);
        run_load(0, 0, 0, -1, 1'b0, 1'b0);
        run_load(0, 1, 0, -1, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            tbl_write($urandom_range(0, NB - 1), $urandom_range(0, NT - 1),
                      16'($urandom));
            run_load($urandom_range(0, NB - 1), $urandom_range(0, 8), 2, -1,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        do_reset();
        step();
        idle_in();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
